// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
//   Round-robin write arbiter and sequencer for a shared 4-entry storage bank.
//   One of four requesters is granted at a time. Its address and data are
//   captured at grant. The bank write enable is then held for HOLD_CYCLES
//   clocks, and a one-cycle ack is pulsed to the winner. Reads are
//   combinational and have no bypass of an in-flight write.
//
// Ports
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   req      : write request, one bit per requester
//   wr_addr  : packed 2-bit target address per requester ([2i+1:2i])
//   wr_data  : packed write data per requester ([WIDTH*(i+1)-1:WIDTH*i])
//   gnt      : one-hot grant, held for the whole transaction
//   ack      : one-cycle completion pulse to the granted requester
//   busy     : high whenever the sequencer is not idle
//   enable   : bank write enable (transparency window)
//   rd_addr  : read address
//   rd_data  : storage[rd_addr], combinational
module latch_bank_arbiter #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [7:0]         wr_addr,
  input  logic [4*WIDTH-1:0] wr_data,
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic               busy,
  output logic               enable,
  input  logic [1:0]         rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [1:0]       idx_r, idx_s;
  logic [1:0]       addr_r, addr_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic [3:0]       gnt_r, gnt_s;
  logic [3:0]       ack_r, ack_s;
  logic             busy_r, busy_s;
  logic             enable_r, enable_s;
  logic             wr_en_s;
  logic [2:0]       pick_s;
  logic [WIDTH-1:0] storage_r [4];

  // Circular search from the pointer. Returns {found, index}. The loop
  // runs from the farthest offset down, so the nearest requester wins.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int o = 3; o >= 0; o--) begin
      c = p + o[1:0];
      if (r[c]) begin
        res = {1'b1, c};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    addr_s   = addr_r;
    data_s   = data_r;
    gnt_s    = gnt_r;
    ack_s    = 4'b0000;
    busy_s   = busy_r;
    enable_s = enable_r;
    wr_en_s  = 1'b0;
    pick_s   = pick(req, ptr_r);
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          // Freeze the winner's address and data for the whole transaction.
          idx_s    = pick_s[1:0];
          addr_s   = wr_addr[2*pick_s[1:0] +: 2];
          data_s   = wr_data[WIDTH*pick_s[1:0] +: WIDTH];
          gnt_s    = 4'b0001 << pick_s[1:0];
          cnt_s    = 4'(HOLD_CYCLES - 1);
          busy_s   = 1'b1;
          enable_s = 1'b1;
          state_s  = WRITE;
        end else begin
          gnt_s    = 4'b0000;
          busy_s   = 1'b0;
          enable_s = 1'b0;
        end
      end
      WRITE: begin
        // The entry is reloaded on every edge while in WRITE.
        wr_en_s = 1'b1;
        if (cnt_r == 4'd0) begin
          state_s  = ACK;
          enable_s = 1'b0;
          ack_s    = gnt_r;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ACK: begin
        // The winner drops to lowest priority for the next arbitration.
        state_s = IDLE;
        gnt_s   = 4'b0000;
        busy_s  = 1'b0;
        ptr_s   = idx_r + 2'd1;
      end
      default: begin
        state_s  = IDLE;
        gnt_s    = 4'b0000;
        busy_s   = 1'b0;
        enable_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      ptr_r    <= 2'd0;
      cnt_r    <= 4'd0;
      idx_r    <= 2'd0;
      addr_r   <= 2'd0;
      data_r   <= '0;
      gnt_r    <= 4'b0000;
      ack_r    <= 4'b0000;
      busy_r   <= 1'b0;
      enable_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      addr_r   <= addr_s;
      data_r   <= data_s;
      gnt_r    <= gnt_s;
      ack_r    <= ack_s;
      busy_r   <= busy_s;
      enable_r <= enable_s;
    end
  end

  // Storage bank. Reset wins over an in-flight write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        storage_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      storage_r[addr_r] <= data_r;
    end else begin
      storage_r[addr_r] <= storage_r[addr_r];
    end
  end

  assign gnt     = gnt_r;
  assign ack     = ack_r;
  assign busy    = busy_r;
  assign enable  = enable_r;
  assign rd_data = storage_r[rd_addr];

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed testbench for latch_bank_arbiter (WIDTH=8, HOLD_CYCLES=2).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_latch_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;
  logic        enable;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;

  int errors = 0;
  int checks = 0;

  latch_bank_arbiter #(.WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr_addr(wr_addr),
    .wr_data(wr_data), .gnt(gnt), .ack(ack), .busy(busy),
    .enable(enable), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Wait (bounded) for the sequencer to go idle.
  task automatic drain(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'hF; wr_addr = 8'hFF; wr_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a); #1;
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd%0d: got %h expected 00", a, rd_data); end
    end
  endtask

  task automatic test_single_write();
    int n;
    reset_n = 1'b1; req = 4'b0100; wr_addr = 8'h30; wr_data = 32'h00A5_0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL sw_gnt: got %b expected 0100", gnt); end
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL sw_enable0: got %b expected 1", enable); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b expected 1", busy); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL sw_ack0: got %b expected 0000", ack); end
    req = 4'b0000; rd_addr = 2'd3; #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL sw_nobypass: got %h expected 00", rd_data); end
    @(negedge clk);
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL sw_enable1: got %b expected 1", enable); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL sw_ack1: got %b expected 0000", ack); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL sw_rd_written: got %h expected a5", rd_data); end
    @(negedge clk);
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL sw_ack: got %b expected 0100", ack); end
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL sw_gnt_held: got %b expected 0100", gnt); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL sw_enable_fall: got %b expected 0", enable); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL sw_idle: got gnt=%b ack=%b busy=%b expected 0000/0000/0", gnt, ack, busy); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL sw_rd_after: got %h expected a5", rd_data); end
    drain(n);
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] eg;
    reset_n = 1'b0; req = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1; wr_addr = 8'hE4; wr_data = 32'h0302_0100; req = 4'hF;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      while (gnt !== 4'b0000 && n < 20) begin @(negedge clk); n++; end
      while (gnt === 4'b0000 && n < 20) begin @(negedge clk); n++; end
      eg = 4'b0001 << (t % 4);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", t, gnt, eg); end
      checks++; if (n != ((t == 0) ? 1 : 4)) begin errors++; $display("FAIL rr_gap%0d: got %0d expected %0d", t, n, (t == 0) ? 1 : 4); end
    end
    req = 4'b0000;
    drain(n);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain: got busy=%b expected 0", busy); end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a); #1;
      checks++; if (rd_data !== 8'(a)) begin errors++; $display("FAIL rr_entry%0d: got %h expected %h", a, rd_data, 8'(a)); end
    end
  endtask

  task automatic test_input_freeze();
    int n;
    req = 4'b0010; wr_addr = 8'h08; wr_data = 32'h0000_1100;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL fz_gnt: got %b expected 0010", gnt); end
    wr_data = 32'hFFFF_FFFF; wr_addr = 8'hFF; req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL fz_ack: got %b expected 0010", ack); end
    @(negedge clk);
    checks++; if (ack !== 4'b0000 || gnt !== 4'b0000) begin errors++; $display("FAIL fz_end: got ack=%b gnt=%b expected 0000/0000", ack, gnt); end
    drain(n);
    rd_addr = 2'd2; #1;
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fz_entry: got %h expected 11", rd_data); end
    rd_addr = 2'd3; #1;
    checks++; if (rd_data !== 8'h03) begin errors++; $display("FAIL fz_other: got %h expected 03", rd_data); end
  endtask

  task automatic test_reset_mid_write();
    int n;
    req = 4'b1000; wr_addr = 8'h00; wr_data = 32'h3C00_0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rm_gnt: got %b expected 1000", gnt); end
    reset_n = 1'b0; req = 4'b0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_abort: got gnt=%b enable=%b busy=%b expected 0000/0/0", gnt, enable, busy); end
    rd_addr = 2'd0; #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rm_entry0: got %h expected 00", rd_data); end
    rd_addr = 2'd2; #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rm_entry2: got %h expected 00", rd_data); end
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rm_noack: got %b expected 0000", ack); end
    reset_n = 1'b1; req = 4'hF; wr_data = 32'h0000_0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_regrant: got %b expected 0001", gnt); end
    req = 4'b0000;
    drain(n);
  endtask

  task automatic test_priority_pointer();
    int n;
    req = 4'b1000;
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL pp_gnt3: got %b expected 1000", gnt); end
    req = 4'b1001;
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL pp_hold: got %b expected 1000", gnt); end
    drain(n);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pp_drain: got busy=%b expected 0", busy); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL pp_gnt0: got %b expected 0001", gnt); end
    req = 4'b0000;
    drain(n);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pp_final: got busy=%b expected 0", busy); end
  endtask

  initial begin
    reset_n = 1'b0; req = 4'b0000; wr_addr = 8'h00; wr_data = 32'h0; rd_addr = 2'd0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_input_freeze();
    test_reset_mid_write();
    test_priority_pointer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latch_bank_arbiter.md
Name: latch_bank_arbiter

Overview:
- Round-robin write arbiter and sequencer for a shared 4-entry storage bank built on the team's enable/reset-controlled latch cells.
- Four requesters compete for write access.
- The block grants one requester at a time and drives the bank's write enable for a programmable transparency window.
- It acknowledges completion and exposes a combinational read port.

Parameters:
- WIDTH, 8, data width of each storage entry
- HOLD_CYCLES, 2, number of clock cycles the write enable stays high per grant (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- req  input  4  write request, one bit per requester
- wr_addr  input  8  packed 2-bit target address per requester; requester i uses bits [2i+1:2i]
- wr_data  input  4*WIDTH  packed write data; requester i uses bits [WIDTH*(i+1)-1:WIDTH*i]
- gnt  output  4  one-hot grant; held for the whole transaction
- ack  output  4  one-cycle completion pulse to the granted requester
- busy  output  1  high in any state other than IDLE
- enable  output  1  bank write enable (transparency window)
- rd_addr  input  2  read address
- rd_data  output  WIDTH  storage[rd_addr], combinational

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk. Takes priority over all other activity.
  - Clears gnt, ack, busy and enable to 0.
  - Clears all four storage entries to 0.
  - Sets the priority pointer to 0 and the FSM to IDLE.
  - Reset asserted mid-transaction aborts it with no ack; a partially written entry is cleared.
- FSM states are IDLE, WRITE and ACK.
- IDLE:
  - If req != 0 at edge k, select the first requesting index at or after the pointer, searching circularly 0..3.
  - Capture that requester's wr_addr and wr_data into internal registers.
  - Set gnt to the one-hot value of the selected index.
  - Set the hold counter to HOLD_CYCLES-1 and go to WRITE.
  - If req == 0, stay in IDLE with all outputs at 0.
- WRITE:
  - enable=1 and busy=1.
  - storage[captured addr] is loaded with captured data on every edge while in WRITE.
  - The counter decrements each cycle.
  - When the counter == 0, go to ACK; enable falls on that edge.
- ACK:
  - ack[granted index]=1 for exactly one cycle; gnt is still held; enable=0.
  - Next edge: go to IDLE, gnt=0, ack=0.
  - The pointer is set to (granted index + 1) mod 4.
- Latency: with req seen at edge k:
  - gnt and enable are high after edge k.
  - The entry is updated at edge k+1.
  - ack is high after edge k+HOLD_CYCLES.
  - The earliest next grant is at edge k+HOLD_CYCLES+2, because IDLE always lasts at least one cycle.
- Captured address and data are frozen at grant. Requester input changes during WRITE have no effect.
- Dropping req during WRITE or ACK does not abort; the write completes and ack is still pulsed.
- Requests from other requesters during a transaction wait. The pointer rotation guarantees that each waiting requester is granted within 3 transactions.
- Holding req high through ack makes the requester re-eligible, but at lowest priority.
- Reads during WRITE return the old value until the edge that writes the entry; there is no bypass.
- gnt is always one-hot or zero. ack is a subset of gnt.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles with req=4'b1111 -> gnt=0, ack=0, enable=0, rd_data=0 for every rd_addr.
2. Single write: req=4'b0100, requester 2 addr=3, data=8'hA5 -> gnt=4'b0100 at the next edge; enable high for 2 cycles; ack[2] pulse 2 cycles after grant; then rd_addr=3 gives rd_data=8'hA5.
3. Round robin: req=4'b1111 held, each requester writing its own index as data -> grant order 0,1,2,3,0; entries hold 0,1,2,3.
4. Input freeze: after grant to requester 1 (data=8'h11), change wr_data to 8'hFF and drop req during WRITE -> the entry holds 8'h11 and ack[1] is still pulsed.
5. Reset mid-WRITE: assert reset_n=0 in the first WRITE cycle of a write of 8'h3C to addr 0 -> no ack, entry 0 = 0, and a new grant after release starts from requester 0.
6. Priority pointer: grant requester 3, then req=4'b1001 -> requester 0 is granted next, not requester 3.
